rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single-ported synchronous instruction/constant ROM (`memory_rom`: `clk`, word address `A`, registered read data `RD`) between the instruction-fetch stage and the load/store stage of the MIPS core. Each cycle it grants at most one requester and drives the ROM word address. One cycle later it routes `RD` back to the granted requester, with a `rvalid` pulse. Fetch has priority, and a burst counter guarantees that loads are never starved. Misaligned byte addresses are rejected with an error response.

## Interface
- `ADDR_W`, 32, byte-address width of both requesters and the ROM `A` port
- `DATA_W`, 32, ROM word width
- `FETCH_BURST`, 4, maximum consecutive fetch grants while a load is waiting (≥1)

- `clk`  in  1  system clock; ROM samples `A` on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  ADDR_W  fetch byte address
- `if_gnt`  out  1  fetch request accepted this cycle (combinational)
- `if_rvalid`  out  1  fetch response valid (registered)
- `if_rdata`  out  DATA_W  fetch response data
- `if_err`  out  1  fetch response is misaligned-address error
- `ls_req`, `ls_addr`, `ls_gnt`, `ls_rvalid`, `ls_rdata`, `ls_err`: same roles as the fetch ports, for load/store
- `rom_a`  out  ADDR_W  ROM word address, `{2'b00, addr[ADDR_W-1:2]}`
- `rom_rd`  in  DATA_W  ROM read data, valid one cycle after `rom_a`

## Operation
- Grant selection, combinational, at most one grant per cycle:
  - only `if_req` high → grant fetch
  - only `ls_req` high → grant load
  - both high → grant fetch, unless `burst_cnt == FETCH_BURST`, in which case grant load
- `burst_cnt` register:
  - increments on a fetch grant while `ls_req` is high, saturating at `FETCH_BURST`
  - clears on any load grant, and on any cycle with `ls_req` low
- ROM address:
  - `rom_a` carries the granted address converted to a word index
  - with no grant, `rom_a` = 0
- Response pipeline registers, captured each clock edge from that cycle's grant:
  - `pend_v` (a grant occurred)
  - `pend_port` (0 = fetch, 1 = load)
  - `pend_err` (granted `addr[1:0] != 0`)
- Response outputs:
  - `X_rvalid = pend_v && pend_port == X`
  - `X_rdata` = `rom_rd` when `X_rvalid && !pend_err`, else 0
  - `X_err` = `X_rvalid && pend_err`
- A misaligned request is still granted. `rom_a` is driven normally, but the returned data is suppressed to 0.
- Back-to-back grants are fully pipelined: throughput is one response per cycle, and a new grant may occur in the same cycle as the previous response.

## Timing
- Reset (asynchronous, active-low): `pend_v`, `pend_port`, `pend_err` and `burst_cnt` clear to 0.
  - All `rvalid`, `err` and `rdata` outputs read 0.
  - `rom_a` = 0 and grants are 0 while `rst_n` is low.
  - An in-flight response is dropped, with no `rvalid` after reset release.
- Latency: `gnt` in cycle N, then `rvalid`/`rdata` in cycle N+1, exactly once per grant.
- Requesters must hold `req` and `addr` until `gnt`. They may drop `req` or change `addr` in the cycle after `gnt`.
- Starvation bound: with `ls_req` held high, load is granted within `FETCH_BURST + 1` cycles.
- Simultaneous events:
  - a response to one port and a grant to the other port in the same cycle are both legal
  - `if_rvalid` and `ls_rvalid` are never high together

## Structure
- Shared package `mips_mem_pkg` holds:
  - `port_id_t` enum (`PORT_IF = 0`, `PORT_LS = 1`)
  - the word-index conversion function
  - the default `ADDR_W` / `DATA_W` constants, also used by `memory_rom`
- One sub-module, `rom_grant_sel`: purely combinational priority/starvation picker (inputs: both `req`s and `burst_cnt`; outputs: one-hot grant).
- The top level holds `burst_cnt`, the response registers and the output muxing.

## Test plan
- Reset mid-flight: grant fetch, then assert `rst_n = 0` before the next edge → no `if_rvalid` ever; all outputs 0 during reset.
- Single fetch, ROM preloaded with `mem[2] = 32'hDEADBEEF`: `if_addr = 32'h8` → `if_gnt` in cycle N, `rom_a = 2`, then `if_rvalid = 1`, `if_rdata = 32'hDEADBEEF`, `if_err = 0` at N+1.
- Back-to-back fetches at 0x0, 0x4, 0x8, 0xC over 4 consecutive cycles → 4 consecutive `if_rvalid` pulses returning `mem[0..3]` in order.
- Contention with `FETCH_BURST = 4`: `if_req` and `ls_req` held high from cycle 0, `ls_addr = 0x10` → fetch grants in cycles 0-3, `ls_gnt` in cycle 4, `ls_rvalid` with `mem[4]` in cycle 5, fetch regranted in cycle 5.
- Misaligned load `ls_addr = 32'h6` → `ls_gnt`, then next cycle `ls_rvalid = 1`, `ls_err = 1`, `ls_rdata = 0`; `burst_cnt` cleared.
- Alternating grants: load only in cycle 0, fetch only in cycle 1 → `ls_rvalid` in cycle 1 coincides with `if_gnt`, `if_rvalid` in cycle 2, never both `rvalid`s high.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-side types and helpers for the MIPS core: port identifiers,
// default ROM widths and the byte-to-word address conversion.
package mips_mem_pkg;

  localparam int ROM_ADDR_W = 32;
  localparam int ROM_DATA_W = 32;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_t;

  // Wide enough for any realistic address width; callers cast in and out.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/rom_grant_sel.sv
// Combinational fetch-priority picker with a load anti-starvation override.
// Output is one-hot: bit PORT_IF for fetch, bit PORT_LS for load/store.
module rom_grant_sel
  import mips_mem_pkg::*;
#(
  parameter int FETCH_BURST = 4,
  parameter int CNT_W       = 3
) (
  input  logic             if_req,
  input  logic             ls_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [1:0]       gnt
);

  logic burst_full;

  assign burst_full = (burst_cnt == CNT_W'(FETCH_BURST));

  always_comb begin
    gnt = 2'b00;
    if (if_req && !(ls_req && burst_full)) begin
      gnt[PORT_IF] = 1'b1;
    end else if (ls_req) begin
      gnt[PORT_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single-ported synchronous ROM between instruction fetch and
// load/store, then steers the registered read data back to the granted port.
module rom_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int FETCH_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_rd
);

  localparam int CNT_W = (FETCH_BURST < 1) ? 1 : $clog2(FETCH_BURST + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_W'(FETCH_BURST)) begin
      return CNT_W'(FETCH_BURST);
    end
    return cnt + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  burst_nxt;
  logic              if_req_p0;
  logic              ls_req_p0;
  logic [1:0]        gnt_p0;
  logic              any_gnt_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic              err_p0;
  logic              pend_v_p1;
  port_id_t          pend_port_p1;
  logic              pend_err_p1;

  // ---- p0: grant, ROM address, misalignment ----
  // Requests are masked while in reset so no grant or address leaks out.
  assign if_req_p0 = if_req & rst_n;
  assign ls_req_p0 = ls_req & rst_n;

  rom_grant_sel #(
    .FETCH_BURST(FETCH_BURST),
    .CNT_W      (CNT_W)
  ) u_grant_sel (
    .if_req   (if_req_p0),
    .ls_req   (ls_req_p0),
    .burst_cnt(burst_cnt),
    .gnt      (gnt_p0)
  );

  assign if_gnt      = gnt_p0[PORT_IF];
  assign ls_gnt      = gnt_p0[PORT_LS];
  assign any_gnt_p0  = |gnt_p0;
  assign sel_addr_p0 = ls_gnt ? ls_addr : if_addr;
  assign err_p0      = any_gnt_p0 && is_misaligned(sel_addr_p0[1:0]);
  assign rom_a       = any_gnt_p0 ? ADDR_W'(word_index(64'(sel_addr_p0))) : '0;

  // Counts fetch grants that pushed a waiting load back; any gap in the
  // load request or a load grant restarts the window.
  always_comb begin
    burst_nxt = burst_cnt;
    if (!ls_req_p0 || ls_gnt) begin
      burst_nxt = '0;
    end else if (if_gnt) begin
      burst_nxt = sat_inc(burst_cnt);
    end
  end

  // ---- p1: response bookkeeping, aligned with ROM read data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt    <= '0;
      pend_v_p1    <= 1'b0;
      pend_port_p1 <= PORT_IF;
      pend_err_p1  <= 1'b0;
    end else begin
      burst_cnt    <= burst_nxt;
      pend_v_p1    <= any_gnt_p0;
      pend_port_p1 <= ls_gnt ? PORT_LS : PORT_IF;
      pend_err_p1  <= err_p0;
    end
  end

  assign if_rvalid = pend_v_p1 && (pend_port_p1 == PORT_IF);
  assign ls_rvalid = pend_v_p1 && (pend_port_p1 == PORT_LS);
  assign if_err    = if_rvalid && pend_err_p1;
  assign ls_err    = ls_rvalid && pend_err_p1;
  assign if_rdata  = (if_rvalid && !pend_err_p1) ? rom_rd : '0;
  assign ls_rdata  = (ls_rvalid && !pend_err_p1) ? rom_rd : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a small behavioural ROM attached.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic [31:0] rom_a;
  logic [31:0] rom_rd;

  logic [31:0] mem [0:15];
  int          checks = 0;
  int          passed = 0;
  logic        both_seen = 1'b0;

  rom_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FETCH_BURST(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .ls_req   (ls_req),
    .ls_addr  (ls_addr),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .ls_err   (ls_err),
    .rom_a    (rom_a),
    .rom_rd   (rom_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_rd <= mem[rom_a[3:0]];

  always @(negedge clk) if (if_rvalid && ls_rvalid) both_seen = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h8; ls_req = 1'b1; ls_addr = 32'h10;
    #2;
    checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err} !== 6'b0 || rom_a !== 32'h0)
      $display("FAIL reset_ctl: gnt/rv/err=%b rom_a=%h, expected 0", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err}, rom_a);
    else passed++;
    step(); step();
    checks++;
    if (if_rdata !== 32'h0 || ls_rdata !== 32'h0 || if_rvalid !== 1'b0)
      $display("FAIL reset_data: if_rdata=%h ls_rdata=%h, expected 0", if_rdata, ls_rdata);
    else passed++;
    rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    step();
    // Mid-flight: grant fetch, then reset before the response edge.
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    checks++;
    if (if_gnt !== 1'b1) $display("FAIL midflight_gnt: if_gnt=%b, expected 1", if_gnt);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_gnt !== 1'b0 || rom_a !== 32'h0)
      $display("FAIL midflight_rst_gnt: if_gnt=%b rom_a=%h, expected 0/0", if_gnt, rom_a);
    else passed++;
    step();
    checks++;
    if ({if_rvalid, if_err, ls_rvalid, ls_err} !== 4'b0 || if_rdata !== 32'h0)
      $display("FAIL midflight_rv_in_rst: rv/err=%b rdata=%h, expected 0", {if_rvalid, if_err, ls_rvalid, ls_err}, if_rdata);
    else passed++;
    if_req = 1'b0; rst_n = 1'b1;
    step();
    checks++;
    if (if_rvalid !== 1'b0) $display("FAIL midflight_no_rv: if_rvalid=%b, expected 0", if_rvalid);
    else passed++;
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || rom_a !== 32'h2)
      $display("FAIL single_gnt: if_gnt=%b ls_gnt=%b rom_a=%h, expected 1/0/2", if_gnt, ls_gnt, rom_a);
    else passed++;
    step();
    if_req = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_err !== 1'b0)
      $display("FAIL single_resp: rv=%b rdata=%h err=%b, expected 1/deadbeef/0", if_rvalid, if_rdata, if_err);
    else passed++;
    checks++;
    if (rom_a !== 32'h0) $display("FAIL idle_rom_a: rom_a=%h, expected 0", rom_a);
    else passed++;
    step();
    checks++;
    if (if_rvalid !== 1'b0) $display("FAIL single_once: if_rvalid=%b, expected 0", if_rvalid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      if_req  = (k < 4);
      if_addr = 32'(k * 4);
      #1;
      if (k < 4) begin
        checks++;
        if (if_gnt !== 1'b1 || rom_a !== 32'(k))
          $display("FAIL b2b_gnt%0d: if_gnt=%b rom_a=%h, expected 1/%0h", k, if_gnt, rom_a, k);
        else passed++;
      end
      if (k > 0) begin
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== mem[k-1])
          $display("FAIL b2b_resp%0d: rv=%b rdata=%h, expected 1/%h", k - 1, if_rvalid, if_rdata, mem[k-1]);
        else passed++;
      end
      step();
    end
    checks++;
    if (if_rvalid !== 1'b0) $display("FAIL b2b_tail: if_rvalid=%b, expected 0", if_rvalid);
    else passed++;
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h20; ls_req = 1'b1; ls_addr = 32'h10;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) ls_req = 1'b0;
      #1;
      if (c < 4) begin
        checks++;
        if (if_gnt !== 1'b1 || ls_gnt !== 1'b0)
          $display("FAIL cont_fetch%0d: if_gnt=%b ls_gnt=%b, expected 1/0", c, if_gnt, ls_gnt);
        else passed++;
      end else if (c == 4) begin
        checks++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || rom_a !== 32'h4)
          $display("FAIL cont_load: ls_gnt=%b if_gnt=%b rom_a=%h, expected 1/0/4", ls_gnt, if_gnt, rom_a);
        else passed++;
      end else begin
        checks++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== mem[4] || if_rvalid !== 1'b0 || if_gnt !== 1'b1)
          $display("FAIL cont_resp: ls_rv=%b ls_rdata=%h if_rv=%b if_gnt=%b, expected 1/%h/0/1", ls_rvalid, ls_rdata, if_rvalid, if_gnt, mem[4]);
        else passed++;
      end
      step();
    end
    if_req = 1'b0;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== mem[8])
      $display("FAIL cont_regrant: if_rv=%b rdata=%h, expected 1/%h", if_rvalid, if_rdata, mem[8]);
    else passed++;
    step();
  endtask

  task automatic test_misaligned();
    if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_addr = 32'h6;
    step();
    checks++;
    if (dut.burst_cnt !== 3'd1) $display("FAIL mis_cnt_pre: burst_cnt=%0d, expected 1", dut.burst_cnt);
    else passed++;
    if_req = 1'b0;
    #1;
    checks++;
    if (ls_gnt !== 1'b1 || rom_a !== 32'h1 || if_rvalid !== 1'b1 || if_rdata !== mem[0])
      $display("FAIL mis_gnt: ls_gnt=%b rom_a=%h if_rv=%b if_rdata=%h, expected 1/1/1/%h", ls_gnt, rom_a, if_rvalid, if_rdata, mem[0]);
    else passed++;
    step();
    ls_req = 1'b0;
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || ls_err !== 1'b1 || ls_rdata !== 32'h0 || if_err !== 1'b0)
      $display("FAIL mis_resp: rv=%b err=%b rdata=%h if_err=%b, expected 1/1/0/0", ls_rvalid, ls_err, ls_rdata, if_err);
    else passed++;
    checks++;
    if (dut.burst_cnt !== 3'd0) $display("FAIL mis_cnt_clr: burst_cnt=%0d, expected 0", dut.burst_cnt);
    else passed++;
    step();
  endtask

  task automatic test_alternating();
    ls_req = 1'b1; ls_addr = 32'hC; if_req = 1'b0;
    #1;
    checks++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || rom_a !== 32'h3)
      $display("FAIL alt_ls_gnt: ls_gnt=%b if_gnt=%b rom_a=%h, expected 1/0/3", ls_gnt, if_gnt, rom_a);
    else passed++;
    step();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h4;
    #1;
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== mem[3] || if_gnt !== 1'b1 || if_rvalid !== 1'b0)
      $display("FAIL alt_cycle1: ls_rv=%b ls_rdata=%h if_gnt=%b if_rv=%b, expected 1/%h/1/0", ls_rvalid, ls_rdata, if_gnt, if_rvalid, mem[3]);
    else passed++;
    step();
    if_req = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== mem[1] || ls_rvalid !== 1'b0)
      $display("FAIL alt_cycle2: if_rv=%b if_rdata=%h ls_rv=%b, expected 1/%h/0", if_rvalid, if_rdata, ls_rvalid, mem[1]);
    else passed++;
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5000000 + 32'(i * 32'h01010101);
    mem[2] = 32'hDEADBEEF;
    mem[4] = 32'hCAFEF00D;
    mem[8] = 32'h12345678;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_addr = '0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_contention();
    test_misaligned();
    test_alternating();
    checks++;
    if (both_seen !== 1'b0) $display("FAIL both_rvalid: seen=%b, expected 0", both_seen);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
